sw_debounce: RTL and testbench



---
 rtl/sw_debounce.sv | 137 +++++++++++++
 tb/tb_sw_debounce.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Per-bit synchroniser, debouncer and edge detector for mechanical board
// inputs (joystick, DIP switches, software-select switches, card detect).
// Raw pad levels are polarity-corrected, brought into the clk_i domain by a
// two-flop synchroniser, and then a per-bit counter requires DebounceCycles
// consecutive cycles of disagreement with the current output before the
// output follows the synchronised level. Every output change produces a
// one-cycle rise or fall pulse aligned with the new level.
//
// Parameters:
//   Width          number of independent input bits
//   DebounceCycles consecutive stable cycles needed to change an output
//                  (1 .. 2^24)
//   Invert         per-bit mask; a set bit inverts the pad level
//   ResetValue     reset value of the synchronisers and of sw_o
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   sw_i       raw pad levels, asynchronous to clk_i
//   sw_o       debounced, polarity-corrected level
//   rise_o     one-cycle pulse when sw_o[i] goes 0 -> 1
//   fall_o     one-cycle pulse when sw_o[i] goes 1 -> 0
//   changed_o  OR of all rise_o and fall_o bits, same cycle
//
// All outputs are registered; nothing combinational reaches an output from
// sw_i.
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int unsigned      Width          = 17,
    parameter int unsigned      DebounceCycles = 200_000,
    parameter logic [Width-1:0] Invert         = '1,
    parameter logic [Width-1:0] ResetValue     = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] sw_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             changed_o
);

    // A single-cycle debounce still needs a one-bit counter so the
    // comparison below stays well formed.
    localparam int unsigned CntW =
        (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    // -------------------------------------------------------------------------
    // Input conditioning and synchroniser.
    // The pad level is corrected for polarity before the first flop; the
    // XOR with a constant mask is the only logic ahead of s1, and nothing
    // sits between s1 and s2. s1 is the asynchronous crossing point.
    // -------------------------------------------------------------------------
    logic [Width-1:0] cond;

    (* ASYNC_REG = "TRUE" *) logic [Width-1:0] s1;
    (* ASYNC_REG = "TRUE" *) logic [Width-1:0] s2;

    assign cond = sw_i ^ Invert;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= ResetValue;
            s2 <= ResetValue;
        end else begin
            s1 <= cond;
            s2 <= s1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit debounce state.
    // Each bit is in one of two states, derived rather than stored:
    //   STABLE  : s2 agrees with sw_o, the counter is held at zero
    //   PENDING : s2 disagrees with sw_o, the counter advances each cycle
    // When a PENDING bit has been counting for DebounceCycles cycles the
    // output takes the synchronised level and the counter returns to zero.
    // Returning to STABLE at any point discards the partial count.
    // -------------------------------------------------------------------------
    logic [CntW-1:0]  cnt_q [Width];
    logic [CntW-1:0]  cnt_d [Width];
    logic [Width-1:0] pending;
    logic [Width-1:0] done;
    logic [Width-1:0] sw_d;
    logic [Width-1:0] rise_d;
    logic [Width-1:0] fall_d;
    logic             changed_d;

    always_comb begin
        pending = '0;
        done    = '0;
        for (int i = 0; i < int'(Width); i++) begin
            cnt_d[i]   = '0;
            pending[i] = s2[i] ^ sw_o[i];
            done[i]    = pending[i] && (cnt_q[i] == CntMax);
            // The counter only advances while pending and short of the
            // final count, so it can never exceed CntMax or wrap.
            if (pending[i] && !done[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // A completed bit flips its output; the new level decides which pulse.
    always_comb begin
        sw_d      = sw_o ^ done;
        rise_d    = done & s2;
        fall_d    = done & ~s2;
        changed_d = |done;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Width); i++) begin
                cnt_q[i] <= '0;
            end
            sw_o      <= ResetValue;
            rise_o    <= '0;
            fall_o    <= '0;
            changed_o <= 1'b0;
        end else begin
            for (int i = 0; i < int'(Width); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sw_o      <= sw_d;
            // Pulses are recomputed every cycle, so each lasts one cycle.
            rise_o    <= rise_d;
            fall_o    <= fall_d;
            changed_o <= changed_d;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// -----------------------------------------------------------------------------
// tb_sw_debounce
//
// Two instances: dut_a (Width=4, DebounceCycles=8, Invert=4'b0011) and
// dut_b (Width=4, DebounceCycles=1, Invert=0). A history-window model
// predicts every output each cycle: an output bit flips at an edge when the
// last DebounceCycles synchronised samples all disagree with it, where the
// synchronised sample seen at edge t is the conditioned pad captured at edge
// t-2. Directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_sw_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_a;
    logic [3:0] sw_b;

    logic [3:0] sw_oa, rise_oa, fall_oa;
    logic       chg_oa;
    logic [3:0] sw_ob, rise_ob, fall_ob;
    logic       chg_ob;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    sw_debounce #(
        .Width(4), .DebounceCycles(8), .Invert(4'b0011), .ResetValue(4'b0000)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .sw_i(sw_a),
        .sw_o(sw_oa), .rise_o(rise_oa), .fall_o(fall_oa), .changed_o(chg_oa)
    );

    sw_debounce #(
        .Width(4), .DebounceCycles(1), .Invert(4'b0000), .ResetValue(4'b0000)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .sw_i(sw_b),
        .sw_o(sw_ob), .rise_o(rise_ob), .fall_o(fall_ob), .changed_o(chg_ob)
    );

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] ha[$];
    logic [3:0] hb[$];
    logic [3:0] m_out_a, m_rise_a, m_fall_a;
    logic [3:0] m_out_b, m_rise_b, m_fall_b;
    logic       m_chg_a, m_chg_b;
    bit         model_ok = 1'b0;

    // Bits that must flip now: every sample in the window disagrees with cur.
    // h[0] is the pad captured at this edge, so the window is h[2]..h[n+1].
    function automatic logic [3:0] flip(input logic [3:0] h[$], input int n,
                                        input logic [3:0] cur);
        logic [3:0] m;
        m = 4'b1111;
        for (int k = 2; k <= n + 1; k++) m = m & (h[k] ^ cur);
        return m;
    endfunction

    initial begin
        logic [3:0] fa, fb;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ha.delete();
                hb.delete();
                for (int k = 0; k < 12; k++) begin
                    ha.push_back(4'b0000);
                    hb.push_back(4'b0000);
                end
                m_out_a = 0; m_rise_a = 0; m_fall_a = 0; m_chg_a = 0;
                m_out_b = 0; m_rise_b = 0; m_fall_b = 0; m_chg_b = 0;
                model_ok = 1'b1;
            end else begin
                ha.push_front(sw_a ^ 4'b0011);
                hb.push_front(sw_b);
                if (ha.size() > 12) ha.delete(12);
                if (hb.size() > 12) hb.delete(12);
                fa = flip(ha, 8, m_out_a);
                fb = flip(hb, 1, m_out_b);
                m_rise_a = fa & ~m_out_a;  m_fall_a = fa & m_out_a;
                m_rise_b = fb & ~m_out_b;  m_fall_b = fb & m_out_b;
                m_out_a  = m_out_a ^ fa;   m_out_b  = m_out_b ^ fb;
                m_chg_a  = |fa;            m_chg_b  = |fb;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("a_sw",   sw_oa,   m_out_a);
                chk("a_rise", rise_oa, m_rise_a);
                chk("a_fall", fall_oa, m_fall_a);
                chk("a_chg",  {3'b0, chg_oa}, {3'b0, m_chg_a});
                chk("a_excl", rise_oa & fall_oa, 4'b0000);
                chk("b_sw",   sw_ob,   m_out_b);
                chk("b_rise", rise_ob, m_rise_b);
                chk("b_fall", fall_ob, m_fall_b);
                chk("b_chg",  {3'b0, chg_ob}, {3'b0, m_chg_b});
                chk("b_excl", rise_ob & fall_ob, 4'b0000);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int rise_cnt, fall_cnt, hi_cnt, first_hi;
        rst_n = 1'b0;
        sw_a  = 4'b0000;
        sw_b  = 4'b0000;

        // Reset state
        settle(3);
        chk("rst_sw",   sw_oa,   4'b0000);
        chk("rst_rise", rise_oa, 4'b0000);
        chk("rst_fall", fall_oa, 4'b0000);
        chk("rst_chg",  {3'b0, chg_oa}, 4'b0000);

        // Release: inverted bits appear at edge 10, one pulse
        @(negedge clk) rst_n = 1'b1;
        settle(9);
        chk("rel_e9_sw", sw_oa, 4'b0000);
        settle(1);
        chk("rel_e10_sw",   sw_oa,   4'b0011);
        chk("rel_e10_rise", rise_oa, 4'b0011);
        chk("rel_e10_chg",  {3'b0, chg_oa}, 4'b0001);
        settle(1);
        chk("rel_e11_rise", rise_oa, 4'b0000);
        chk("rel_e11_chg",  {3'b0, chg_oa}, 4'b0000);
        settle(8);

        // Clean step on bit 2
        @(negedge clk) sw_a = 4'b0100;
        settle(9);
        chk("step_e9_sw", sw_oa, 4'b0011);
        settle(1);
        chk("step_e10_sw",   sw_oa,   4'b0111);
        chk("step_e10_rise", rise_oa, 4'b0100);
        chk("step_e10_fall", fall_oa, 4'b0000);
        settle(5);

        // Bounce on bit 3: 7 high, 3 low, ten times
        for (int r = 0; r < 10; r++) begin
            @(negedge clk) sw_a[3] = 1'b1;
            repeat (7) @(negedge clk);
            sw_a[3] = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("bounce_sw", sw_oa, 4'b0111);
        @(negedge clk) sw_a[3] = 1'b1;
        settle(9);
        chk("hold_e9_sw", sw_oa, 4'b0111);
        settle(1);
        chk("hold_e10_sw",   sw_oa,   4'b1111);
        chk("hold_e10_rise", rise_oa, 4'b1000);
        settle(3);

        // Simultaneous events on bits 0 and 2
        @(negedge clk) sw_a = 4'b1001;
        settle(14);
        chk("sim_pre_sw", sw_oa, 4'b1010);
        @(negedge clk) sw_a = 4'b1100;
        settle(10);
        chk("sim_sw",   sw_oa,   4'b1111);
        chk("sim_rise", rise_oa, 4'b0101);
        chk("sim_fall", fall_oa, 4'b0000);
        chk("sim_chg",  {3'b0, chg_oa}, 4'b0001);
        settle(1);
        chk("sim_chg_after", {3'b0, chg_oa}, 4'b0000);
        settle(3);

        // Reset in the middle of a count on bit 2
        @(negedge clk) sw_a = 4'b1000;
        settle(14);
        chk("mid_pre_sw", sw_oa, 4'b1011);
        @(negedge clk) sw_a = 4'b1100;
        settle(7);
        chk("mid_cnt5_sw", sw_oa, 4'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sw",   sw_oa,   4'b0000);
        chk("mid_rst_rise", rise_oa, 4'b0000);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        settle(9);
        chk("mid_e9_sw", sw_oa, 4'b0000);
        settle(1);
        chk("mid_e10_sw",   sw_oa,   4'b1111);
        chk("mid_e10_rise", rise_oa, 4'b1111);
        settle(3);

        // Minimum debounce: 3-cycle pad pulse on dut_b bit 0
        rise_cnt = 0; fall_cnt = 0; hi_cnt = 0; first_hi = -1;
        @(negedge clk) sw_b = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            settle(1);
            if (i == 2) sw_b = 4'b0000;
            if (rise_ob[0]) rise_cnt++;
            if (fall_ob[0]) fall_cnt++;
            if (sw_ob[0]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        chk("min_hi_cnt",   hi_cnt[3:0],   4'd3);
        chk("min_first_hi", first_hi[3:0], 4'd2);
        chk("min_rise_cnt", rise_cnt[3:0], 4'd1);
        chk("min_fall_cnt", fall_cnt[3:0], 4'd1);

        settle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
